// File: rtl/mu_pipe.sv
// mu_pipe: two-stage fixed-point multiply / multiply-accumulate pipeline.
// LANES independent signed lanes share one valid/ready handshake. S1 holds
// full-precision products, S2 holds scaled, range-checked results and the
// per-lane accumulators. A downstream stall freezes both stages.
module mu_pipe #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 12,
    parameter int LANES  = 1,
    parameter int SAT_EN = 1,
    parameter int RND_EN = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    mode,
    input  logic                    acc_clr,
    input  logic [LANES*DATA_W-1:0] data_w,
    input  logic [LANES*DATA_W-1:0] data_i,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [LANES-1:0]        ovf
);

    localparam int PW = 2 * DATA_W;
    localparam int WW = 2 * DATA_W + 2;

    typedef logic signed [WW-1:0] wide_t;

    localparam wide_t MAX_V = (wide_t'(1) <<< (DATA_W - 1)) - wide_t'(1);
    localparam wide_t MIN_V = -(wide_t'(1) <<< (DATA_W - 1));
    localparam wide_t RND_V = (RND_EN != 0) ? (wide_t'(1) <<< (FRAC_W - 1)) : wide_t'(0);

    // Optional half-up rounding, then arithmetic shift back to the Q format.
    function automatic wide_t scale_p(input logic signed [PW-1:0] p);
        wide_t v;
        v = wide_t'(p) + RND_V;
        return v >>> FRAC_W;
    endfunction

    function automatic logic out_of_range(input wide_t v);
        return (v > MAX_V) || (v < MIN_V);
    endfunction

    // Clamp to the nearest limit, or keep the low DATA_W bits when wrapping.
    function automatic logic signed [DATA_W-1:0] fit(input wide_t v);
        logic signed [DATA_W-1:0] r;
        if ((SAT_EN != 0) && (v > MAX_V)) begin
            r = MAX_V[DATA_W-1:0];
        end else if ((SAT_EN != 0) && (v < MIN_V)) begin
            r = MIN_V[DATA_W-1:0];
        end else begin
            r = v[DATA_W-1:0];
        end
        return r;
    endfunction

    logic                     w_stall;
    logic                     r_vld_p1;
    logic                     r_mode_p1;
    logic                     r_clr_p1;
    logic signed [PW-1:0]     r_prod_p1 [LANES];
    logic                     r_vld_p2;
    logic [LANES*DATA_W-1:0]  r_out_p2;
    logic [LANES-1:0]         r_ovf_p2;
    logic signed [DATA_W-1:0] r_acc [LANES];
    logic signed [PW-1:0]     w_prod [LANES];
    logic signed [DATA_W-1:0] w_res [LANES];
    logic [LANES-1:0]         w_ovf;

    assign w_stall   = r_vld_p2 && !out_ready;
    assign in_ready  = !w_stall;
    assign out_valid = r_vld_p2;
    assign out_data  = r_out_p2;
    assign ovf       = r_ovf_p2;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic signed [PW-1:0] w_a;
        logic signed [PW-1:0] w_b;
        wide_t                w_s;
        wide_t                w_sum;

        assign w_a       = PW'($signed(data_i[k*DATA_W +: DATA_W]));
        assign w_b       = PW'($signed(data_w[k*DATA_W +: DATA_W]));
        assign w_prod[k] = w_a * w_b;

        // acc_clr restarts the sum from zero instead of the stored value.
        assign w_s       = scale_p(r_prod_p1[k]);
        assign w_sum     = (r_clr_p1 ? wide_t'(0) : wide_t'(r_acc[k])) + w_s;
        assign w_res[k]  = r_mode_p1 ? fit(w_sum) : fit(w_s);
        assign w_ovf[k]  = out_of_range(w_s) || (r_mode_p1 && out_of_range(w_sum));
    end

    // ---- S1: capture full-precision products and beat attributes when the pipe moves
    always_ff @(posedge clk) begin
        if (!w_stall) begin
            r_mode_p1 <= mode;
            r_clr_p1  <= acc_clr;
            for (int k = 0; k < LANES; k++) begin
                r_prod_p1[k] <= w_prod[k];
            end
        end
    end

    // ---- S2: advance valid bits and load results/accumulators for valid beats only
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            r_out_p2 <= '0;
            r_ovf_p2 <= '0;
            for (int k = 0; k < LANES; k++) begin
                r_acc[k] <= '0;
            end
        end else if (!w_stall) begin
            r_vld_p1 <= in_valid;
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_ovf_p2 <= w_ovf;
                for (int k = 0; k < LANES; k++) begin
                    r_out_p2[k*DATA_W +: DATA_W] <= w_res[k];
                    if (r_mode_p1) begin
                        r_acc[k] <= w_res[k];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mu_pipe.sv
// tb_mu_pipe: directed-vector bench for mu_pipe. Two single-lane instances
// (saturating/truncating and wrapping/rounding) share one input stream; a
// four-lane instance covers per-lane independence.
module tb_mu_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid, mode, acc_clr, out_ready;
    logic [15:0] di, dw;
    logic        rdy0, ov0, rdyw, ovw;
    logic [15:0] od0, odw;
    logic [0:0]  of0, ofw;

    logic        iv4, m4, c4, or4;
    logic [63:0] di4, dw4;
    logic        rdy4, ov4;
    logic [63:0] od4;
    logic [3:0]  of4;

    int n_vec = 0;
    int n_err = 0;

    mu_pipe #(.DATA_W(16), .FRAC_W(12), .LANES(1), .SAT_EN(1), .RND_EN(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0),
        .mode(mode), .acc_clr(acc_clr), .data_w(dw), .data_i(di),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .ovf(of0));

    mu_pipe #(.DATA_W(16), .FRAC_W(12), .LANES(1), .SAT_EN(0), .RND_EN(1)) dutw (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdyw),
        .mode(mode), .acc_clr(acc_clr), .data_w(dw), .data_i(di),
        .out_valid(ovw), .out_ready(out_ready), .out_data(odw), .ovf(ofw));

    mu_pipe #(.DATA_W(16), .FRAC_W(12), .LANES(4), .SAT_EN(1), .RND_EN(0)) dut4 (
        .clk(clk), .reset(reset), .in_valid(iv4), .in_ready(rdy4),
        .mode(m4), .acc_clr(c4), .data_w(dw4), .data_i(di4),
        .out_valid(ov4), .out_ready(or4), .out_data(od4), .ovf(of4));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        mode;
        logic        clr;
        logic [15:0] di;
        logic [15:0] dw;
        logic [15:0] e0;
        logic        f0;
        logic [15:0] ew;
        logic        fw;
    } vec_t;

    vec_t tv [18];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic beat(input logic m, input logic c, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        mode     = m;
        acc_clr  = c;
        di       = a;
        dw       = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    logic [15:0] held;
    logic        held_ok;
    int          idx, got;
    logic [15:0] exp_s [5];

    initial begin
        // columns: mode clr di dw | sat/trunc result, ovf | wrap/round result, ovf
        tv[0]  = '{1'b0, 1'b0, 16'h1000, 16'h2000, 16'h2000, 1'b0, 16'h2000, 1'b0};
        tv[1]  = '{1'b0, 1'b0, 16'hF000, 16'h1800, 16'hE800, 1'b0, 16'hE800, 1'b0};
        tv[2]  = '{1'b0, 1'b0, 16'h7000, 16'h7000, 16'h7FFF, 1'b1, 16'h1000, 1'b1};
        tv[3]  = '{1'b0, 1'b0, 16'h0001, 16'h0800, 16'h0000, 1'b0, 16'h0001, 1'b0};
        tv[4]  = '{1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b0};
        tv[5]  = '{1'b0, 1'b0, 16'h8000, 16'h7FFF, 16'h8000, 1'b1, 16'h0008, 1'b1};
        tv[6]  = '{1'b0, 1'b0, 16'h7FFF, 16'h1000, 16'h7FFF, 1'b0, 16'h7FFF, 1'b0};
        tv[7]  = '{1'b0, 1'b0, 16'h8000, 16'h1000, 16'h8000, 1'b0, 16'h8000, 1'b0};
        tv[8]  = '{1'b0, 1'b0, 16'h8000, 16'hF000, 16'h7FFF, 1'b1, 16'h8000, 1'b1};
        tv[9]  = '{1'b1, 1'b1, 16'h1000, 16'h0800, 16'h0800, 1'b0, 16'h0800, 1'b0};
        tv[10] = '{1'b1, 1'b0, 16'h1000, 16'h0800, 16'h1000, 1'b0, 16'h1000, 1'b0};
        tv[11] = '{1'b1, 1'b0, 16'h1000, 16'h0800, 16'h1800, 1'b0, 16'h1800, 1'b0};
        tv[12] = '{1'b0, 1'b0, 16'h1000, 16'h2000, 16'h2000, 1'b0, 16'h2000, 1'b0};
        tv[13] = '{1'b1, 1'b0, 16'h1000, 16'h0800, 16'h2000, 1'b0, 16'h2000, 1'b0};
        tv[14] = '{1'b1, 1'b1, 16'h1000, 16'h0800, 16'h0800, 1'b0, 16'h0800, 1'b0};
        tv[15] = '{1'b1, 1'b0, 16'h7000, 16'h2000, 16'h7FFF, 1'b1, 16'hE800, 1'b1};
        tv[16] = '{1'b1, 1'b0, 16'h1000, 16'h0800, 16'h7FFF, 1'b1, 16'hF000, 1'b0};
        tv[17] = '{1'b1, 1'b1, 16'hF000, 16'h1000, 16'hF000, 1'b0, 16'hF000, 1'b0};

        reset = 1'b0;
        in_valid = 1'b0; mode = 1'b0; acc_clr = 1'b0; di = '0; dw = '0; out_ready = 1'b1;
        iv4 = 1'b0; m4 = 1'b0; c4 = 1'b0; di4 = '0; dw4 = '0; or4 = 1'b1;

        // reset state
        #12;
        chk("rst_out_valid", ov0, 0);
        chk("rst_out_data", od0, 0);
        chk("rst_ovf", of0, 0);
        chk("rst_in_ready", rdy0, 1);
        chk("rst_out_data4", od4, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("post_rst_in_ready", rdy0, 1);

        // table-driven single beats
        for (int v = 0; v < 18; v++) begin
            beat(tv[v].mode, tv[v].clr, tv[v].di, tv[v].dw);
            chk($sformatf("v%0d_lat1_valid", v), ov0, 0);
            @(negedge clk);
            chk($sformatf("v%0d_valid", v), ov0, 1);
            chk($sformatf("v%0d_sat_data", v), od0, tv[v].e0);
            chk($sformatf("v%0d_sat_ovf", v), of0, tv[v].f0);
            chk($sformatf("v%0d_wrap_data", v), odw, tv[v].ew);
            chk($sformatf("v%0d_wrap_ovf", v), ofw, tv[v].fw);
        end

        // 5-beat stream with a 3-cycle downstream stall
        for (int k = 0; k < 5; k++) exp_s[k] = 16'(16'h1000 * (k + 1));
        @(negedge clk);
        @(negedge clk);
        idx = 0; got = 0; held_ok = 1'b0; held = '0;
        for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 3 && cyc < 6);
            if (idx < 5) begin
                in_valid = 1'b1; mode = 1'b0; acc_clr = 1'b0;
                di = exp_s[idx]; dw = 16'h1000;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (ov0 && out_ready) begin
                chk($sformatf("stream_out%0d", got), od0, exp_s[got]);
                got++;
            end
            if (ov0 && !out_ready) begin
                chk($sformatf("stall_in_ready_c%0d", cyc), rdy0, 0);
                if (held_ok) chk($sformatf("stall_hold_c%0d", cyc), od0, held);
                held = od0;
                held_ok = 1'b1;
            end else begin
                held_ok = 1'b0;
            end
            if (in_valid && rdy0) idx++;
        end
        chk("stream_count", got, 5);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;

        // four lanes, one overflowing
        @(negedge clk);
        iv4 = 1'b1;
        di4 = {16'h0800, 16'hF000, 16'h7000, 16'h1000};
        dw4 = {16'h0800, 16'h1800, 16'h7000, 16'h2000};
        @(negedge clk);
        iv4 = 1'b0;
        @(negedge clk);
        chk("lanes4_valid", ov4, 1);
        chk("lanes4_data", od4, {16'h0400, 16'hE800, 16'h7FFF, 16'h2000});
        chk("lanes4_ovf", of4, 4'b0010);

        // reset with two beats in flight and acc = 0x1800
        beat(1'b1, 1'b1, 16'h1000, 16'h0800);
        beat(1'b1, 1'b0, 16'h1000, 16'h0800);
        beat(1'b1, 1'b0, 16'h1000, 16'h0800);
        @(negedge clk);
        chk("acc_build", od0, 16'h1800);
        @(negedge clk);
        in_valid = 1'b1; mode = 1'b1; acc_clr = 1'b0; di = 16'h1000; dw = 16'h1000;
        @(negedge clk);
        di = 16'h2000;
        @(negedge clk);
        in_valid = 1'b0;
        chk("inflight_valid", ov0, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_out_valid", ov0, 0);
        chk("midrst_out_data", od0, 0);
        chk("midrst_in_ready", rdy0, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("inflight_discarded", ov0, 0);
        beat(1'b1, 1'b0, 16'h1000, 16'h0800);
        @(negedge clk);
        chk("post_rst_mac_valid", ov0, 1);
        chk("post_rst_mac_data", od0, 16'h0800);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
